freq_meas_sequencer: RTL and testbench

- Single-clock controller on the 100 MHz board clock. It sequences the two PLL-output event counters through lock qualification, clear, a fixed gate window, a settle period and a result capture.
- It presents frozen count pairs to the hex display path and a result-valid flag.
- Counter enable and clear leave this block as level signals. Count values return as quasi-static buses, sampled only while the counters are disabled.

---
 rtl/freq_meas_sequencer.sv | 161 ++++++++++++++++
 tb/tb_freq_meas_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_sequencer.sv
// Frequency measurement sequencer.
// Runs the two PLL-output event counters through lock qualification, clear,
// a fixed gate window, a settle period and a result capture. It then holds
// the frozen count pair for the hex display path.
module freq_meas_sequencer #(
  parameter int CNT_W         = 34,
  parameter int GATE_CYCLES   = 100000000,
  parameter int LOCK_STABLE   = 1024,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             pll_lock_i,
  input  logic [CNT_W-1:0] cnt1_i,
  input  logic [CNT_W-1:0] cnt2_i,
  output logic             cnt_clr_o,
  output logic             cnt_en_o,
  output logic [CNT_W-1:0] res1_o,
  output logic [CNT_W-1:0] res2_o,
  output logic             res_valid_o,
  output logic             sat_o,
  output logic             lock_err_o,
  output logic             busy_o,
  output logic [2:0]       state_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] CLEAR     = 3'd2;
  localparam logic [2:0] GATE      = 3'd3;
  localparam logic [2:0] SETTLE    = 3'd4;
  localparam logic [2:0] CAPTURE   = 3'd5;
  localparam logic [2:0] HOLD      = 3'd6;

  // One shared phase timer serves CLEAR, GATE, SETTLE and HOLD. It is sized
  // for the longest of the four phases.
  localparam int TMR_MAX_A = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int TMR_MAX_B = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int LOCK_W    = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

  localparam logic [TMR_W-1:0]  CLR_LAST    = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_STABLE - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [TMR_W-1:0]  tmr;
  logic [LOCK_W-1:0] lock_cnt;
  logic              lock_m;
  logic              lock_s;
  logic              start_q;
  logic              start_rise;
  logic              lock_loss;
  logic              timed_state;

  assign state_o     = state;
  assign start_rise  = start_i & ~start_q;
  assign lock_loss   = !lock_s && (state == CLEAR || state == GATE || state == SETTLE);
  assign timed_state = (state == CLEAR) || (state == GATE) ||
                       (state == SETTLE) || (state == HOLD);

  // Lock synchroniser and start edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m  <= 1'b0;
      lock_s  <= 1'b0;
      // NOTE: the previous-value flop resets to 1, so a start_i that is
      // already high when reset is released does not count as an edge.
      start_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples pre-edge values, whatever order the statements are in.
      lock_m  <= pll_lock_i;
      lock_s  <= lock_m;
      start_q <= start_i;
    end
  end

  // Next-state decode. A lock loss in an active phase always wins over
  // phase completion.
  always_comb begin
    // NOTE: the default assignment comes first so that every path writes
    // state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:      if (start_rise || continuous_i) state_nx = WAIT_LOCK;
      WAIT_LOCK: if (lock_s && lock_cnt == LOCK_LAST) state_nx = CLEAR;
      CLEAR:     if (!lock_s) state_nx = WAIT_LOCK;
                 else if (tmr == CLR_LAST) state_nx = GATE;
      GATE:      if (!lock_s) state_nx = WAIT_LOCK;
                 else if (tmr == GATE_LAST) state_nx = SETTLE;
      SETTLE:    if (!lock_s) state_nx = WAIT_LOCK;
                 else if (tmr == SETTLE_LAST) state_nx = CAPTURE;
      CAPTURE:   state_nx = HOLD;
      HOLD:      if (tmr == HOLD_LAST) state_nx = continuous_i ? WAIT_LOCK : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State, timers, registered counter controls and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      lock_cnt    <= '0;
      cnt_clr_o   <= 1'b0;
      cnt_en_o    <= 1'b0;
      busy_o      <= 1'b0;
      res1_o      <= '0;
      res2_o      <= '0;
      res_valid_o <= 1'b0;
      sat_o       <= 1'b0;
      lock_err_o  <= 1'b0;
    end else begin
      state <= state_nx;

      // Phase timer: zero on every state entry, and it advances only in the
      // timed phases, so it never runs past its terminal value.
      if (state_nx != state || !timed_state) tmr <= '0;
      else                                   tmr <= tmr + 1'b1;

      // Lock stability count: any low lock_s sample restarts the count.
      if (state != WAIT_LOCK || state_nx != WAIT_LOCK || !lock_s) lock_cnt <= '0;
      else                                                         lock_cnt <= lock_cnt + 1'b1;

      // The outputs decode from the next state, so each output is high for
      // exactly the cycles spent in the matching state.
      cnt_clr_o <= (state_nx == CLEAR);
      cnt_en_o  <= (state_nx == GATE);
      busy_o    <= (state_nx != IDLE);

      // A new measurement is pending once the counters are being cleared.
      if (state == WAIT_LOCK && state_nx == CLEAR) res_valid_o <= 1'b0;

      // Sample the quiescent counters on the way into CAPTURE. A run that
      // gets here saw no lock loss, so any stale error flag is cleared.
      if (state == SETTLE && state_nx == CAPTURE) begin
        res1_o      <= cnt1_i;
        res2_o      <= cnt2_i;
        res_valid_o <= 1'b1;
        sat_o       <= (&cnt1_i) | (&cnt2_i);
        lock_err_o  <= 1'b0;
      end

      // Abort on lock loss: the results are kept, but they are no longer valid.
      if (lock_loss) begin
        res_valid_o <= 1'b0;
        lock_err_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed testbench for freq_meas_sequencer, using short timing parameters.
module tb_freq_meas_sequencer;

  localparam int CNT_W = 34;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_GATE    = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             continuous_i;
  logic             pll_lock_i;
  logic [CNT_W-1:0] cnt1_i;
  logic [CNT_W-1:0] cnt2_i;
  logic             cnt_clr_o;
  logic             cnt_en_o;
  logic [CNT_W-1:0] res1_o;
  logic [CNT_W-1:0] res2_o;
  logic             res_valid_o;
  logic             sat_o;
  logic             lock_err_o;
  logic             busy_o;
  logic [2:0]       state_o;

  // Event counters under test control: +2 and +3 per enabled cycle.
  logic [CNT_W-1:0] cnt1_q = '0;
  logic [CNT_W-1:0] cnt2_q = '0;
  logic             force_sat;

  // Monitor totals, sampled on the rising edge (pre-update values).
  int cyc         = 0;
  int en_total    = 0;
  int clr_total   = 0;
  int idle_total  = 0;
  int valid_rises = 0;
  logic valid_prev = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cnt1_i = force_sat ? ALL_ONES : cnt1_q;
  assign cnt2_i = cnt2_q;

  freq_meas_sequencer #(
    .CNT_W(CNT_W), .GATE_CYCLES(10), .LOCK_STABLE(4),
    .CLR_CYCLES(2), .SETTLE_CYCLES(3), .HOLD_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .continuous_i(continuous_i),
    .pll_lock_i(pll_lock_i), .cnt1_i(cnt1_i), .cnt2_i(cnt2_i),
    .cnt_clr_o(cnt_clr_o), .cnt_en_o(cnt_en_o), .res1_o(res1_o), .res2_o(res2_o),
    .res_valid_o(res_valid_o), .sat_o(sat_o), .lock_err_o(lock_err_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always @(posedge clk) begin
    if (cnt_clr_o) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else if (cnt_en_o) begin
      cnt1_q <= cnt1_q + 34'd2;
      cnt2_q <= cnt2_q + 34'd3;
    end
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    en_total   <= en_total + int'(cnt_en_o);
    clr_total  <= clr_total + int'(cnt_clr_o);
    idle_total <= idle_total + int'(state_o == S_IDLE);
    if (res_valid_o && !valid_prev) valid_rises <= valid_rises + 1;
    valid_prev <= res_valid_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Count consecutive cycles spent in state st, from the current sample on.
  task automatic wait_len(input logic [2:0] st, output int n);
    n = 0;
    while (state_o === st && n < 300) begin
      n++;
      tick();
    end
  endtask

  // Advance until state st is reached; a timeout shows up as a failed check.
  task automatic wait_state(input logic [2:0] st, input string tag);
    int n = 0;
    while (state_o !== st && n < 400) begin
      n++;
      tick();
    end
    check(tag, state_o, st);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int n;
    int en0, clr0, v0, idle0;
    int cap_cyc [3];

    rst = 1'b1; start_i = 1'b0; continuous_i = 1'b0;
    pll_lock_i = 1'b1; force_sat = 1'b0;
    tick(); tick(); tick();

    // Reset state.
    check("rst_state", state_o, S_IDLE);
    check("rst_en", cnt_en_o, 0);
    check("rst_clr", cnt_clr_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_lock_err", lock_err_o, 0);
    check("rst_res1", res1_o, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_after_rst", state_o, S_IDLE);

    // Nominal run: phase lengths and captured values.
    en0 = en_total; clr0 = clr_total;
    pulse_start();
    check("t1_enter_wait", state_o, S_WAIT);
    wait_len(S_WAIT, n);   check("t1_wait_len", n, 4);
    check("t1_clr_hi", cnt_clr_o, 1);
    wait_len(S_CLEAR, n);  check("t1_clear_len", n, 2);
    check("t1_en_hi", cnt_en_o, 1);
    wait_len(S_GATE, n);   check("t1_gate_len", n, 10);
    check("t1_en_lo", cnt_en_o, 0);
    check("t1_valid_pending", res_valid_o, 0);
    wait_len(S_SETTLE, n); check("t1_settle_len", n, 3);
    check("t1_capture", state_o, S_CAPTURE);
    check("t1_valid", res_valid_o, 1);
    check("t1_res1", res1_o, 20);
    check("t1_res2", res2_o, 30);
    check("t1_sat", sat_o, 0);
    check("t1_lock_err", lock_err_o, 0);
    wait_len(S_CAPTURE, n); check("t1_capture_len", n, 1);
    wait_len(S_HOLD, n);    check("t1_hold_len", n, 5);
    check("t1_back_idle", state_o, S_IDLE);
    check("t1_busy_lo", busy_o, 0);
    check("t1_en_cycles", en_total - en0, 10);
    check("t1_clr_cycles", clr_total - clr0, 2);

    // Saturation of counter 1.
    force_sat = 1'b1;
    pulse_start();
    wait_state(S_CAPTURE, "t2_reach_capture");
    check("t2_sat", sat_o, 1);
    check("t2_res1", res1_o, ALL_ONES);
    check("t2_res2", res2_o, 30);
    wait_state(S_IDLE, "t2_reach_idle");
    force_sat = 1'b0;

    // Lock lost in gate cycle 5, then recovery.
    pulse_start();
    wait_state(S_GATE, "t3_reach_gate");
    tick(); tick(); tick(); tick();
    pll_lock_i = 1'b0;
    tick(); tick(); tick();
    check("t3_en_dropped", cnt_en_o, 0);
    check("t3_lock_err", lock_err_o, 1);
    check("t3_state_wait", state_o, S_WAIT);
    check("t3_valid_lo", res_valid_o, 0);
    check("t3_res1_kept", res1_o, ALL_ONES);
    check("t3_res2_kept", res2_o, 30);
    pll_lock_i = 1'b1;
    wait_state(S_GATE, "t3_regate");
    check("t3_err_sticky", lock_err_o, 1);
    wait_state(S_CAPTURE, "t3_recapture");
    check("t3_err_cleared", lock_err_o, 0);
    check("t3_valid", res_valid_o, 1);
    check("t3_res1", res1_o, 20);
    check("t3_res2", res2_o, 30);
    wait_state(S_IDLE, "t3_reach_idle");

    // Continuous mode: three back-to-back runs.
    v0 = valid_rises;
    idle0 = 0;
    continuous_i = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      wait_state(S_CAPTURE, "t4_reach_capture");
      cap_cyc[r] = cyc;
      if (r == 0) idle0 = idle_total;
      if (r < 2) tick();
    end
    check("t4_no_idle", idle_total - idle0, 0);
    continuous_i = 1'b0;
    check("t4_period_1", cap_cyc[1] - cap_cyc[0], 25);
    check("t4_period_2", cap_cyc[2] - cap_cyc[1], 25);
    wait_state(S_IDLE, "t4_reach_idle");
    check("t4_valid_rises", valid_rises - v0, 3);

    // Synchronous reset in GATE.
    pulse_start();
    wait_state(S_GATE, "t5_reach_gate");
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_state", state_o, S_IDLE);
    check("t5_en", cnt_en_o, 0);
    check("t5_res1", res1_o, 0);
    check("t5_res2", res2_o, 0);
    check("t5_valid", res_valid_o, 0);
    check("t5_busy", busy_o, 0);

    // start_i held high through reset release is not an edge.
    start_i = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("t6_stays_idle", state_o, S_IDLE);
    check("t6_busy_lo", busy_o, 0);
    start_i = 1'b0;
    tick();
    pulse_start();
    check("t6_fresh_start", state_o, S_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
